// File: rtl/apb_cmd_master.sv
// APB3 initiator: converts a valid/ready command stream into single APB transfers
// and returns read data / error status on a valid/ready response stream.
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  RegClk,
    input  logic                  RegReset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge RegClk) begin
        if (RegReset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= SETUP;
                        wait_cnt  <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state       <= RESP;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                    end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_LAST) begin
                        // Hung slave: abandon the transfer and report it as an error.
                        state       <= RESP;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= 32'h0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Retiring a response and accepting a command never share a cycle.
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB initiator that turns a simple valid/ready command stream into single APB3 transfers toward the generated register blocks, and returns read data and error status on a valid/ready response stream. It is the master-side counterpart to the register slaves. It lets a sequencer, debug bridge or test engine program registers and push write-FIFO data without hand-driving APB phases. Only one transfer is outstanding at a time; a PREADY timeout guards against a hung slave.

## Interface
- ADDR_WIDTH, 8, width of cmd_addr/PADDR.
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables timeout. Counter width = clog2(TIMEOUT_CYCLES+1), minimum 1.
- RegClk  input  1  sole clock, all logic on posedge.
- RegReset  input  1  reset; one clock, synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  byte address.
- cmd_wdata  input  32  write data (ignored for reads).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  output  32  captured PRDATA for reads; 0 for writes and timeouts.
- rsp_err  output  1  PSLVERR at completion, or 1 on timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- busy  output  1  state != IDLE.
- PSEL, PENABLE, PWRITE  output  1 each  APB control.
- PADDR  output  ADDR_WIDTH  APB address.
- PWDATA  output  32  APB write data.
- PRDATA  input  32  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs registered.
- IDLE: cmd_ready=1. On accept, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA; go to SETUP.
- SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Sample on each edge:
  - If PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR, rsp_timeout=0. Go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and the wait counter equals TIMEOUT_CYCLES-1: rsp_rdata=0, rsp_err=1, rsp_timeout=1. Go to RESP.
  - Otherwise increment the wait counter.
- Wait counter clears on entry to SETUP.
- RESP: PSEL=PENABLE=0, rsp_valid=1. Response fields are held stable until rsp_ready=1, then go to IDLE.
- PADDR/PWDATA/PWRITE are held at the last command outside SETUP/ACCESS and never change while PSEL=1.
- cmd_ready=0 in SETUP, ACCESS and RESP. No command is accepted in the same cycle a response retires.

## Timing
- Reset values: state IDLE, cmd_ready=1 after reset release, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0.
- Accept at edge N, zero wait states:
  - SETUP visible cycle N+1.
  - ACCESS cycle N+2.
  - rsp_valid cycle N+3.
  - With rsp_ready=1, IDLE at N+4 and next accept at N+4 (4-cycle throughput).
- Each PREADY=0 cycle in ACCESS adds one cycle.
- Timeout: with PREADY stuck at 0, ACCESS lasts exactly TIMEOUT_CYCLES cycles, then rsp_valid rises.
- PREADY=1 on the final allowed cycle counts as normal completion, not a timeout.
- RegReset asserted in any state: next edge returns to reset values. Any in-flight transfer and pending response are dropped; PSEL deasserts without a completion.
- cmd_valid asserted during reset is not accepted.

## Test plan
- Write 0x00 ← 0x25, PREADY=1 → SETUP/ACCESS at N+1/N+2 with PADDR=0x00, PWDATA=0x25, PWRITE=1; rsp_valid at N+3 with rsp_rdata=0, rsp_err=0.
- Read 0x0C with slave driving PRDATA=0x0000001F → rsp_rdata=0x1F, rsp_err=0, PWRITE=0 during transfer.
- Read 0x10 with slave PSLVERR=1 at completion → rsp_err=1, rsp_timeout=0.
- PREADY low 3 cycles in ACCESS → ACCESS lasts 4 cycles; PADDR/PWDATA stable throughout; response correct.
- TIMEOUT_CYCLES=16, PREADY stuck 0 → abort after 16 ACCESS cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0; next command proceeds normally.
- rsp_ready held 0 for 5 cycles → rsp fields stable, cmd_ready=0. Then RegReset pulsed in ACCESS of a new transfer → all outputs at reset values next cycle, no rsp_valid.
